piso_serial_tx: RTL and testbench
=================================

# piso_serial_tx

Parallel-in, serial-out frame transmitter that drains a WIDTH-bit parallel word onto a single serial line. It sits downstream of the team's parallel-load registers: a word presented on `I` with `load` is captured and sent as a framed bit stream. Each frame is a start bit, the data bits LSB first, then a stop bit, with every bit held for CLKS_PER_BIT clocks. It is the reader/transmit end of the parallel-load register interface, and pairs with a future serial-in receiver.

## Interface
- `WIDTH`, default 4: data bits per frame; must be ≥ 1.
- `CLKS_PER_BIT`, default 2: clocks each serial bit is held; must be ≥ 1.
- `clk` in 1: single clock; all state updates on its rising edge.
- `clr` in 1: reset, asynchronous and active-high.
- `I` in WIDTH: parallel data word.
- `load` in 1: request to capture `I`; honoured only when `ready`=1.
- `ready` out 1: transmitter idle, load will be accepted.
- `busy` out 1: frame in progress; always the complement of `ready`.
- `so` out 1: serial output; idles high.
- `done` out 1: one-cycle pulse after a frame's stop bit completes.

## Operation
- **States:** IDLE, START, DATA, STOP.
- **IDLE**
  - `so`=1, `ready`=1.
  - On a clock edge with `load`=1: shift register ← `I`, bit timer ← 0, bit counter ← 0, go to START.
- **START**
  - `so`=0.
  - When the bit timer reaches CLKS_PER_BIT-1: timer ← 0, go to DATA. Otherwise the timer increments.
- **DATA**
  - `so` = shift register bit 0.
  - At timer terminal count:
    - shift register ← logical shift right by one;
    - bit counter increments;
    - after bit WIDTH-1 is sent, go to STOP.
- **STOP**
  - `so`=1.
  - At timer terminal count go to IDLE and set `done` for exactly one cycle.
- **Ignored loads:** `load` during START, DATA or STOP is ignored; the captured word is never altered mid-frame.
- **Back-to-back frames:** `load` in the cycle `done`=1 is accepted, because the state is IDLE. The next START begins with no idle gap beyond that one cycle.
- **Width rules:**
  - bit timer width is $clog2(CLKS_PER_BIT), minimum 1;
  - bit counter width is $clog2(WIDTH+1).
  - Neither counter is allowed to wrap past its terminal value.
- **Output decode:** all outputs are decoded from registered state only. There is no combinational path from `load` or `I` to any output.

## Timing
- **Reset values (while `clr`=1):** state IDLE, `so`=1, `ready`=1, `busy`=0, `done`=0, shift register 0, counters 0.
- **Reset mid-frame:** `clr` asserted during any state aborts the frame immediately, without waiting for a clock. `so` returns to 1 and `done` is not pulsed.
- **Load latency:** `so` falls in the cycle following the accepting edge E0.
- **Frame length:** (WIDTH+2)·CLKS_PER_BIT cycles. The state returns to IDLE at edge E0+(WIDTH+2)·CLKS_PER_BIT, and `done` is high for the cycle after that edge.
- **Load with `clr`:** `clr` and `load` asserted together means `clr` wins and nothing is captured.

## Structure
- **Shared package:** holds the state typedef (IDLE/START/DATA/STOP enum) and the idle-line level constant (1). A future receiver will import the same package.
- **Sub-module:** one sub-module, `piso_bit_timer`.
  - It is a mod-CLKS_PER_BIT counter with synchronous restart, async `clr`, and a terminal-count output.
  - It is instantiated once.
  - The FSM, shift register and bit counter stay in the top module.

## Test plan
Parameters are WIDTH=4, CLKS_PER_BIT=2 unless stated.
- **Reset:** assert `clr` asynchronously mid-cycle → `so`=1, `ready`=1, `busy`=0, `done`=0 immediately, before any clock edge.
- **Single frame:** `I`=4'b1010, `load` for one cycle → `so` per cycle is 0,0,0,0,1,1,0,0,1,1,1,1. `done`=1 in cycle 13 only. `ready` returns to 1 in cycle 13.
- **Busy-load ignored:** start a frame with `I`=4'b0001, then pulse `load` with `I`=4'b1111 in cycle 5 → the data bits remain 1,0,0,0 and exactly one `done` pulse occurs.
- **Back-to-back:** hold `load`=1 continuously with `I`=4'b0110 → two frames separated by exactly one idle cycle (`so`=1) coinciding with `done`. Data bits are 0,1,1,0 in each frame.
- **Reset mid-operation:** assert `clr` in DATA cycle 6 of a frame → `so`=1 with no `done` pulse. A subsequent load of 4'b0011 produces a clean frame.
- **Parameter sweep:** WIDTH=8, CLKS_PER_BIT=1, `I`=8'hA5 → `so` is 0,1,0,1,0,0,1,0,1,1 and `done` is high in cycle 11.

Source files
------------

// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the PISO transmitter and its future serial-in receiver.
// Holds the frame state encoding, idle line level and counter sizing helper.
package piso_serial_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;

   // Counter width for a mod-n count; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// Mod-CLKS_PER_BIT bit-period timer with synchronous restart and terminal count.
module piso_bit_timer
   import piso_serial_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic restart,
   output logic tc_c
);

   localparam int unsigned TMR_W = cnt_width(CLKS_PER_BIT);
   localparam logic [TMR_W-1:0] TERM = TMR_W'(CLKS_PER_BIT - 1);

   logic [TMR_W-1:0] cnt;

   assign tc_c = (cnt == TERM);

   // Wraps to zero at terminal count so it never runs past CLKS_PER_BIT-1.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt <= '0;
      end else if (restart || tc_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + TMR_W'(1);
      end
   end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH data bits LSB first,
// stop bit, each held CLKS_PER_BIT clocks. All outputs are registered.
module piso_serial_tx
   import piso_serial_tx_pkg::*;
#(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned CLKS_PER_BIT = 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] I,
   input  logic             load,
   output logic             ready,
   output logic             busy,
   output logic             so,
   output logic             done
);

   localparam int unsigned BCNT_W = $clog2(WIDTH + 1);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);

   tx_state_t          state;
   logic [WIDTH-1:0]   sh;
   logic [WIDTH-1:0]   sh_next_c;
   logic [BCNT_W-1:0]  bit_cnt;
   logic               tc_c;
   logic               tmr_restart_c;

   // Timer is held at zero while idle so each frame starts a fresh bit period.
   assign tmr_restart_c = (state == IDLE);
   assign sh_next_c     = sh >> 1;

   piso_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .clr     (clr),
      .restart (tmr_restart_c),
      .tc_c    (tc_c)
   );

   // Frame FSM; outputs are loaded with the values belonging to the next state.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state   <= IDLE;
         sh      <= '0;
         bit_cnt <= '0;
         so      <= LINE_IDLE;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  state   <= START;
                  sh      <= I;
                  bit_cnt <= '0;
                  so      <= 1'b0;
                  ready   <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            START: begin
               if (tc_c) begin
                  state <= DATA;
                  so    <= sh[0];
               end
            end
            DATA: begin
               if (tc_c) begin
                  sh      <= sh_next_c;
                  bit_cnt <= bit_cnt + BCNT_W'(1);
                  if (bit_cnt == LAST_BIT) begin
                     state <= STOP;
                     so    <= LINE_IDLE;
                  end else begin
                     so <= sh_next_c[0];
                  end
               end
            end
            STOP: begin
               if (tc_c) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               so    <= LINE_IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench for piso_serial_tx: stimulus queues per-cycle expected
// {so,done,ready,busy}; a monitor per instance pops and compares on each falling edge.
module tb_piso_serial_tx;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] i_a = '0;
   logic       load_a = 1'b0;
   logic       ready_a, busy_a, so_a, done_a;
   logic [7:0] i_b = '0;
   logic       load_b = 1'b0;
   logic       ready_b, busy_b, so_b, done_b;

   int vectors = 0;
   int miscompares = 0;

   logic [3:0] qa[$];
   logic [3:0] qb[$];

   localparam logic [3:0] E_IDLE = 4'b1010;
   localparam logic [3:0] E_DONE = 4'b1110;

   always #5 clk = ~clk;

   piso_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(2)) dut_a (
      .clk(clk), .clr(clr), .I(i_a), .load(load_a),
      .ready(ready_a), .busy(busy_a), .so(so_a), .done(done_a)
   );

   piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_b (
      .clk(clk), .clr(clr), .I(i_b), .load(load_b),
      .ready(ready_b), .busy(busy_b), .so(so_b), .done(done_b)
   );

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got {so,done,ready,busy}=%b, expected %b at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] frame_ent(input logic bit_v);
      return {bit_v, 3'b001};
   endfunction

   always @(negedge clk) begin
      if (qa.size() > 0) check("dut_a cycle", {so_a, done_a, ready_a, busy_a}, qa.pop_front());
      if (qb.size() > 0) check("dut_b cycle", {so_b, done_b, ready_b, busy_b}, qb.pop_front());
   end

   // Drive for one cycle and queue the outputs expected after the previous edge.
   task automatic cyc_a(input logic ld, input logic [3:0] din, input logic [3:0] exp);
      load_a = ld;
      i_a    = din;
      qa.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_b(input logic ld, input logic [7:0] din, input logic [3:0] exp);
      load_b = ld;
      i_b    = din;
      qb.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] seq_1010;
      logic [11:0] seq_0001;
      logic [11:0] seq_0110;
      logic [11:0] seq_0011;
      logic [9:0]  seq_a5;
      seq_1010 = 12'hF30;  // 0,0,0,0,1,1,0,0,1,1,1,1 (index 0 first)
      seq_0001 = 12'hC0C;  // 0,0,1,1,0,0,0,0,0,0,1,1
      seq_0110 = 12'hCF0;  // 0,0,0,0,1,1,1,1,0,0,1,1
      seq_0011 = 12'hC3C;  // 0,0,1,1,1,1,0,0,0,0,1,1
      seq_a5   = 10'h34A;  // 0,1,0,1,0,0,1,0,1,1

      // Asynchronous reset before any clock edge
      #2 clr = 1'b1;
      #1;
      check("reset_a", {so_a, done_a, ready_a, busy_a}, E_IDLE);
      check("reset_b", {so_b, done_b, ready_b, busy_b}, E_IDLE);
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr = 1'b0;

      // Single frame 1010
      cyc_a(1'b1, 4'b1010, E_IDLE);
      for (int k = 1; k <= 12; k++) cyc_a(1'b0, 4'b1010, frame_ent(seq_1010[k-1]));
      cyc_a(1'b0, 4'b0000, E_DONE);
      cyc_a(1'b0, 4'b0000, E_IDLE);

      // Load of 1111 during frame 0001 is ignored
      cyc_a(1'b1, 4'b0001, E_IDLE);
      for (int k = 1; k <= 12; k++) begin
         if (k == 5) cyc_a(1'b1, 4'b1111, frame_ent(seq_0001[k-1]));
         else        cyc_a(1'b0, 4'b0001, frame_ent(seq_0001[k-1]));
      end
      cyc_a(1'b0, 4'b0000, E_DONE);
      cyc_a(1'b0, 4'b0000, E_IDLE);

      // Back-to-back frames with load held high
      cyc_a(1'b1, 4'b0110, E_IDLE);
      for (int k = 1; k <= 12; k++) cyc_a(1'b1, 4'b0110, frame_ent(seq_0110[k-1]));
      cyc_a(1'b1, 4'b0110, E_DONE);
      for (int k = 14; k <= 25; k++) cyc_a(1'b1, 4'b0110, frame_ent(seq_0110[k-14]));
      cyc_a(1'b0, 4'b0000, E_DONE);
      cyc_a(1'b0, 4'b0000, E_IDLE);

      // Reset in DATA cycle 6 aborts the frame without a done pulse
      cyc_a(1'b1, 4'b1010, E_IDLE);
      for (int k = 1; k <= 5; k++) cyc_a(1'b0, 4'b1010, frame_ent(seq_1010[k-1]));
      clr = 1'b1;
      #1;
      check("midframe_reset", {so_a, done_a, ready_a, busy_a}, E_IDLE);
      qa.push_back(E_IDLE);
      @(posedge clk); #1;
      clr = 1'b0;
      cyc_a(1'b0, 4'b0000, E_IDLE);
      cyc_a(1'b0, 4'b0000, E_IDLE);
      cyc_a(1'b0, 4'b0000, E_IDLE);
      cyc_a(1'b1, 4'b0011, E_IDLE);
      for (int k = 1; k <= 12; k++) cyc_a(1'b0, 4'b0011, frame_ent(seq_0011[k-1]));
      cyc_a(1'b0, 4'b0000, E_DONE);
      cyc_a(1'b0, 4'b0000, E_IDLE);

      // WIDTH=8, CLKS_PER_BIT=1 instance with A5
      cyc_b(1'b1, 8'hA5, E_IDLE);
      for (int k = 1; k <= 10; k++) cyc_b(1'b0, 8'hA5, frame_ent(seq_a5[k-1]));
      cyc_b(1'b0, 8'h00, E_DONE);
      cyc_b(1'b0, 8'h00, E_IDLE);

      @(negedge clk);
      #1;
      if (qa.size() != 0 || qb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got %0d/%0d pending entries, expected 0/0", qa.size(), qb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
